// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus owner with registered one-hot grant, mux select and turnaround
module bus_arbiter #(
  parameter int N_MASTERS = 4,
  parameter int SEL_WIDTH = $clog2(N_MASTERS),
  parameter int MAX_HOLD  = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_MASTERS-1:0] req,
  output logic [N_MASTERS-1:0] grant,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 bus_busy,
  output logic                 preempted
);
  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
  localparam logic [CNT_WIDTH-1:0] HOLD_MAX = CNT_WIDTH'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);
  state_t               state;
  logic [SEL_WIDTH-1:0] ptr;
  logic [SEL_WIDTH-1:0] win;
  logic [CNT_WIDTH-1:0] hold_cnt;
  logic                 timeout;
  assign timeout = MAX_HOLD != 0 && hold_cnt == HOLD_MAX && |(req & ~grant);
  // first requester at or after ptr, wrapping through the power-of-two index space
  always_comb begin
    win = ptr;
    for (int i = N_MASTERS - 1; i >= 0; i--)
      if (req[ptr + SEL_WIDTH'(i)]) win = ptr + SEL_WIDTH'(i);
  end
  // arbitration FSM; grant ends through a one-cycle TURN so sel never moves under an active grant
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      sel       <= '0;
      bus_busy  <= 1'b0;
      preempted <= 1'b0;
      hold_cnt  <= '0;
      ptr       <= '0;
    end else begin
      preempted <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          state    <= GRANT;
          grant    <= N_MASTERS'(1) << win;
          sel      <= win;
          bus_busy <= 1'b1;
          hold_cnt <= '0;
          ptr      <= win + 1'b1;
        end
        GRANT: if (!req[sel] || timeout) begin
          state     <= TURN;
          grant     <= '0;
          bus_busy  <= 1'b0;
          preempted <= req[sel];
        end else if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
